axis_pkt_gen: RTL and testbench
===============================

Name: axis_pkt_gen

Overview:
- AXI4-Stream master (transmitter) that produces framed packets of incrementing-data beats with TLAST.
- Drives the slave (s00_axis) port of the stream FIFO in board bring-up and loopback tests, in place of the DMA.
- Software or a test controller configures it and starts it with a single pulse.
- Fully honours TREADY backpressure, with optional idle gaps between packets.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32, data width in bits; a multiple of 8.
- C_LEN_WIDTH, 8, width of the beats-per-packet field.
- C_CNT_WIDTH, 16, width of the packet-count field.
- C_GAP_WIDTH, 8, width of the inter-packet gap field.

Ports:
- m00_axis_aclk  in  1  sole clock.
- m00_axis_areset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- stop  in  1  graceful stop request; takes effect at the next packet boundary.
- pkt_len  in  C_LEN_WIDTH  beats per packet; valid range 1..2^C_LEN_WIDTH-1.
- num_pkts  in  C_CNT_WIDTH  number of packets per run; valid range 1..max.
- gap  in  C_GAP_WIDTH  idle cycles between packets; 0 means back-to-back.
- seed  in  C_M_AXIS_TDATA_WIDTH  data value of the first beat.
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- done  out  1  one-cycle pulse when a run ends.
- pkts_sent  out  C_CNT_WIDTH  packets completed in the current or last run.
- m00_axis_tvalid  out  1  AXI-Stream TVALID.
- m00_axis_tdata  out  C_M_AXIS_TDATA_WIDTH  AXI-Stream TDATA.
- m00_axis_tstrb  out  C_M_AXIS_TDATA_WIDTH/8  AXI-Stream TSTRB; tied to all ones.
- m00_axis_tlast  out  1  AXI-Stream TLAST.
- m00_axis_tready  in  1  AXI-Stream TREADY.

Behaviour:
- Reset values:
  - state IDLE; tvalid, tlast, busy, done = 0; tdata = 0; pkts_sent = 0.
  - Reset mid-packet drops tvalid immediately; no completion of the packet.
- Handshake: a beat transfers when tvalid && tready on a rising edge.
  - Once tvalid is high, tvalid, tdata and tlast hold stable until the transfer.
  - tvalid never depends combinationally on tready.
  - All outputs are registered.
- States: IDLE, SEND, GAP, DONE.
- IDLE:
  - start with pkt_len != 0 and num_pkts != 0: latch pkt_len, num_pkts, gap and seed; load tdata = seed; clear beat_cnt and pkts_sent; go to SEND.
  - Latency: tvalid is high the cycle after start.
  - start with pkt_len == 0 or num_pkts == 0: ignored; stays IDLE; busy and done remain 0.
- SEND:
  - tvalid = 1; tlast = (beat_cnt == pkt_len-1).
  - On each transfer: tdata <= tdata + 1, wrapping modulo 2^C_M_AXIS_TDATA_WIDTH.
  - The data sequence is continuous across packets; it does not restart per packet.
- Last-beat transfer:
  - pkts_sent increments and beat_cnt clears.
  - If pkts_sent+1 == num_pkts, or stop was latched: go to DONE, tvalid 0.
  - Else if gap == 0: stay in SEND with tvalid continuously high (back-to-back).
  - Else go to GAP with tvalid 0.
- GAP:
  - Exactly gap cycles with tvalid low, counted by gap_cnt.
  - Then SEND, or DONE if stop was latched.
- DONE: done = 1 for one cycle, busy = 1 in that cycle, then IDLE.
  - pkts_sent holds its value until the next accepted start.
- stop:
  - Latched into stop_req in any non-IDLE state.
  - Never truncates a packet.
  - If the run is in GAP, it ends at the end of the gap.
  - Cleared on entry to IDLE.
  - stop while IDLE is ignored.
- Simultaneous events:
  - start while busy: ignored.
  - stop and the final last-beat transfer in the same cycle: normal DONE, a single done pulse.
- pkt_len == 1: every beat carries tlast.
- tready held low: the generator stalls indefinitely in SEND with no state change.

Decomposition:
- Shared include axis_gen_defs.vh holds:
  - state encodings (IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3);
  - the default width constants.
- No sub-module. Counters (beat_cnt, gap_cnt, pkts_sent) and the FSM live in one file.
- The module is reused by the FIFO testbench as its stimulus source.

Test Plan:
- start with pkt_len=4, num_pkts=2, gap=0, seed=0x10, tready=1 -> 8 consecutive beats 0x10..0x17; tlast on 0x13 and 0x17; done pulses the cycle after beat 0x17; pkts_sent=2.
- pkt_len=3, num_pkts=2, gap=5, seed=0 -> beats 0,1,2(last); exactly 5 cycles tvalid=0; beats 3,4,5(last); then done.
- pkt_len=16, num_pkts=1, tready toggling pseudo-randomly (50%) -> tdata/tlast stable whenever tvalid && !tready; 16 transfers 0..15; tlast only on 15; no dropped or duplicated beats.
- num_pkts=10, pkt_len=4, stop pulsed during beat 2 of packet 3 -> packet 3 completes with tlast; done follows; pkts_sent=3; no 4th packet.
- start with pkt_len=0, and separately with num_pkts=0 -> no tvalid, busy=0, done=0.
- A second start during a run is ignored; areset asserted mid-packet -> next cycle tvalid=0, busy=0, pkts_sent=0.
- seed=0xFFFFFFFE, pkt_len=4 -> data FFFFFFFE, FFFFFFFF, 0, 1.

Source files
------------

// File: rtl/axis_pkt_gen_pkg.sv
// Shared definitions for the AXI4-Stream packet generator: FSM state encoding
// and default parameter widths.
package axis_pkt_gen_pkg;

  localparam int DEF_TDATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH   = 8;
  localparam int DEF_CNT_WIDTH   = 16;
  localparam int DEF_GAP_WIDTH   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } gen_state_t;

endpackage

// File: rtl/axis_pkt_gen.sv
// AXI4-Stream master that emits framed packets of incrementing data beats,
// with optional idle gaps, graceful stop and full TREADY backpressure.
module axis_pkt_gen
  import axis_pkt_gen_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
  parameter int C_LEN_WIDTH          = DEF_LEN_WIDTH,
  parameter int C_CNT_WIDTH          = DEF_CNT_WIDTH,
  parameter int C_GAP_WIDTH          = DEF_GAP_WIDTH
) (
  input  logic                                m00_axis_aclk,
  input  logic                                m00_axis_areset,
  input  logic                                start,
  input  logic                                stop,
  input  logic [C_LEN_WIDTH-1:0]              pkt_len,
  input  logic [C_CNT_WIDTH-1:0]              num_pkts,
  input  logic [C_GAP_WIDTH-1:0]              gap,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]     seed,
  output logic                                busy,
  output logic                                done,
  output logic [C_CNT_WIDTH-1:0]              pkts_sent,
  output logic                                m00_axis_tvalid,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                                m00_axis_tlast,
  input  logic                                m00_axis_tready
);

  localparam logic [C_LEN_WIDTH-1:0]          LEN_ONE  = {{(C_LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_CNT_WIDTH-1:0]          CNT_ONE  = {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_GAP_WIDTH-1:0]          GAP_ONE  = {{(C_GAP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [C_M_AXIS_TDATA_WIDTH-1:0] DATA_ONE = {{(C_M_AXIS_TDATA_WIDTH-1){1'b0}}, 1'b1};

  gen_state_t                state;
  logic [C_LEN_WIDTH-1:0]    beat_cnt;
  logic [C_GAP_WIDTH-1:0]    gap_cnt;
  logic [C_LEN_WIDTH-1:0]    len_lat;
  logic [C_CNT_WIDTH-1:0]    num_lat;
  logic [C_GAP_WIDTH-1:0]    gap_lat;
  logic                      stop_req;
  logic                      last_beat;
  logic                      end_run;

  assign m00_axis_tstrb = '1;
  assign last_beat      = (beat_cnt == len_lat - LEN_ONE);
  // A stop arriving in the same cycle as a boundary is honoured at that boundary.
  assign end_run        = stop_req || stop;

  always_ff @(posedge m00_axis_aclk) begin
    if (m00_axis_areset) begin
      state           <= ST_IDLE;
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pkts_sent       <= '0;
      beat_cnt        <= '0;
      gap_cnt         <= '0;
      stop_req        <= 1'b0;
      len_lat         <= '0;
      num_lat         <= '0;
      gap_lat         <= '0;
    end else begin
      done <= 1'b0;
      if (state != ST_IDLE && stop) begin
        stop_req <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start && pkt_len != '0 && num_pkts != '0) begin
            len_lat         <= pkt_len;
            num_lat         <= num_pkts;
            gap_lat         <= gap;
            m00_axis_tdata  <= seed;
            beat_cnt        <= '0;
            pkts_sent       <= '0;
            m00_axis_tvalid <= 1'b1;
            m00_axis_tlast  <= (pkt_len == LEN_ONE);
            busy            <= 1'b1;
            state           <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (m00_axis_tready) begin
            m00_axis_tdata <= m00_axis_tdata + DATA_ONE;
            if (last_beat) begin
              pkts_sent <= pkts_sent + CNT_ONE;
              beat_cnt  <= '0;
              if ((pkts_sent + CNT_ONE) == num_lat || end_run) begin
                m00_axis_tvalid <= 1'b0;
                m00_axis_tlast  <= 1'b0;
                done            <= 1'b1;
                state           <= ST_DONE;
              end else if (gap_lat == '0) begin
                m00_axis_tlast <= (len_lat == LEN_ONE);
              end else begin
                m00_axis_tvalid <= 1'b0;
                m00_axis_tlast  <= 1'b0;
                gap_cnt         <= '0;
                state           <= ST_GAP;
              end
            end else begin
              beat_cnt       <= beat_cnt + LEN_ONE;
              m00_axis_tlast <= ((beat_cnt + LEN_ONE) == (len_lat - LEN_ONE));
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == gap_lat - GAP_ONE) begin
            if (end_run) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              m00_axis_tvalid <= 1'b1;
              m00_axis_tlast  <= (len_lat == LEN_ONE);
              state           <= ST_SEND;
            end
          end else begin
            gap_cnt <= gap_cnt + GAP_ONE;
          end
        end
        ST_DONE: begin
          busy     <= 1'b0;
          stop_req <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: table-driven runs plus random runs
// compared against an arithmetic model of the expected beat stream.
module tb_axis_pkt_gen;

  localparam int DW = 32;
  localparam int LW = 8;
  localparam int CW = 16;
  localparam int GW = 8;

  logic          clk = 1'b0;
  logic          areset;
  logic          start;
  logic          stop;
  logic [LW-1:0] pkt_len;
  logic [CW-1:0] num_pkts;
  logic [GW-1:0] gap;
  logic [DW-1:0] seed;
  logic          busy;
  logic          done;
  logic [CW-1:0] pkts_sent;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tstrb;
  logic          tlast;
  logic          tready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_pkt_gen #(
    .C_M_AXIS_TDATA_WIDTH(DW),
    .C_LEN_WIDTH(LW),
    .C_CNT_WIDTH(CW),
    .C_GAP_WIDTH(GW)
  ) dut (
    .m00_axis_aclk(clk),
    .m00_axis_areset(areset),
    .start(start),
    .stop(stop),
    .pkt_len(pkt_len),
    .num_pkts(num_pkts),
    .gap(gap),
    .seed(seed),
    .busy(busy),
    .done(done),
    .pkts_sent(pkts_sent),
    .m00_axis_tvalid(tvalid),
    .m00_axis_tdata(tdata),
    .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast),
    .m00_axis_tready(tready)
  );

  typedef struct {
    int          len;
    int          num;
    int          gapCycles;
    logic [31:0] seedVal;
    int          readyPct;
    int          stopBeat;
    int          midStart;
    int          expPkts;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Model: packets sent is num, cut short after the packet holding the stop beat.
  function automatic int modelPkts(input vec_t v);
    int p;
    p = v.num;
    if (v.stopBeat >= 0 && (v.stopBeat / v.len) + 1 < p) p = (v.stopBeat / v.len) + 1;
    return p;
  endfunction

  task automatic applyStimulus(input vec_t v);
    int          k;
    int          lastXfer;
    int          lowRun;
    int          total;
    bit          prevStall;
    bit          doneSeen;
    bit          rdy;
    logic [31:0] prevData;
    logic        prevLast;
    logic [31:0] expData;
    total     = modelPkts(v) * v.len;
    k         = 0;
    lastXfer  = -10;
    lowRun    = 0;
    prevStall = 1'b0;
    doneSeen  = 1'b0;
    prevData  = '0;
    prevLast  = 1'b0;
    @(negedge clk);
    pkt_len  = LW'(v.len);
    num_pkts = CW'(v.num);
    gap      = GW'(v.gapCycles);
    seed     = v.seedVal;
    tready   = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_latency_tvalid", 64'(tvalid), 64'(1));
    checkOutput("start_busy", 64'(busy), 64'(1));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prevStall) begin
        checkOutput("stall_tvalid", 64'(tvalid), 64'(1));
        checkOutput("stall_tdata", 64'(tdata), 64'(prevData));
        checkOutput("stall_tlast", 64'(tlast), 64'(prevLast));
      end
      if (done) begin
        doneSeen = 1'b1;
        checkOutput("done_beats", 64'(k), 64'(total));
        checkOutput("done_pkts_sent", 64'(pkts_sent), 64'(v.expPkts));
        checkOutput("done_busy", 64'(busy), 64'(1));
        checkOutput("done_tvalid", 64'(tvalid), 64'(0));
        checkOutput("done_timing", 64'(lastXfer), 64'(cyc - 1));
        break;
      end
      rdy    = ($urandom_range(99) < v.readyPct);
      tready = rdy;
      stop   = (tvalid && k == v.stopBeat);
      if (cyc == v.midStart) begin
        start = 1'b1;
        seed  = 32'hDEAD_BEEF;
      end
      if (tvalid && rdy) begin
        expData = v.seedVal + 32'(k);
        checkOutput("extra_beat", 64'(k < total), 64'(1));
        checkOutput("beat_tdata", 64'(tdata), 64'(expData));
        checkOutput("beat_tlast", 64'(tlast), 64'((k % v.len) == v.len - 1));
        if (k > 0 && (k % v.len) == 0) checkOutput("gap_len", 64'(lowRun), 64'(v.gapCycles));
        k++;
        lastXfer = cyc;
        lowRun   = 0;
      end else if (!tvalid) begin
        lowRun++;
      end
      prevStall = tvalid && !rdy;
      prevData  = tdata;
      prevLast  = tlast;
      @(negedge clk);
      stop  = 1'b0;
      start = 1'b0;
      seed  = v.seedVal;
    end
    if (!doneSeen) checkOutput("run_timeout", 64'(0), 64'(1));
    tready = 1'b0;
    @(negedge clk);
    checkOutput("post_done_busy", 64'(busy), 64'(0));
    checkOutput("post_done_pulse", 64'(done), 64'(0));
    checkOutput("post_done_pkts_hold", 64'(pkts_sent), 64'(v.expPkts));
  endtask

  initial begin
    vec_t rv;
    bit   stalled;
    areset   = 1'b1;
    start    = 1'b0;
    stop     = 1'b0;
    pkt_len  = '0;
    num_pkts = '0;
    gap      = '0;
    seed     = '0;
    tready   = 1'b0;

    vecs[0] = '{4,  2,  0, 32'h10,       100, -1, -1, 2};
    vecs[1] = '{3,  2,  5, 32'h0,        100, -1, -1, 2};
    vecs[2] = '{16, 1,  0, 32'h0,        50,  -1, -1, 1};
    vecs[3] = '{4,  10, 0, 32'h20,       100, 9,  -1, 3};
    vecs[4] = '{4,  1,  0, 32'hFFFF_FFFE, 100, -1, -1, 1};
    vecs[5] = '{1,  5,  2, 32'h7,        70,  -1, -1, 5};
    vecs[6] = '{4,  3,  2, 32'h100,      100, -1, 3,  3};
    vecs[7] = '{5,  4,  3, 32'h55,       60,  12, -1, 3};

    repeat (3) @(negedge clk);
    areset = 1'b0;
    @(negedge clk);
    checkOutput("reset_tvalid", 64'(tvalid), 64'(0));
    checkOutput("reset_tlast", 64'(tlast), 64'(0));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_tdata", 64'(tdata), 64'(0));
    checkOutput("reset_pkts_sent", 64'(pkts_sent), 64'(0));
    checkOutput("tstrb_ones", 64'(tstrb), 64'(4'hF));

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Degenerate starts must be ignored.
    for (int z = 0; z < 2; z++) begin
      @(negedge clk);
      pkt_len  = (z == 0) ? LW'(0) : LW'(4);
      num_pkts = (z == 0) ? CW'(3) : CW'(0);
      tready   = 1'b1;
      start    = 1'b1;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        start = 1'b0;
        checkOutput("zero_cfg_tvalid", 64'(tvalid), 64'(0));
        checkOutput("zero_cfg_busy", 64'(busy), 64'(0));
        checkOutput("zero_cfg_done", 64'(done), 64'(0));
      end
    end

    // Backpressure held low: output frozen on the first beat.
    @(negedge clk);
    pkt_len  = LW'(3);
    num_pkts = CW'(1);
    gap      = GW'(0);
    seed     = 32'h40;
    tready   = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checkOutput("hold_tvalid", 64'(tvalid), 64'(1));
      checkOutput("hold_tdata", 64'(tdata), 64'(32'h40));
      @(negedge clk);
    end
    tready  = 1'b1;
    stalled = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checkOutput("release_tdata", 64'(tdata), 64'(32'h40 + c));
      checkOutput("release_tlast", 64'(tlast), 64'(c == 2));
      @(negedge clk);
    end
    checkOutput("release_done", 64'(done), 64'(1));
    @(negedge clk);

    // Reset mid-run drops everything on the next cycle.
    pkt_len  = LW'(2);
    num_pkts = CW'(5);
    gap      = GW'(0);
    seed     = 32'h0;
    tready   = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_tvalid", 64'(tvalid), 64'(1));
    checkOutput("pre_reset_pkts", 64'(pkts_sent), 64'(2));
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    checkOutput("midreset_tvalid", 64'(tvalid), 64'(0));
    checkOutput("midreset_busy", 64'(busy), 64'(0));
    checkOutput("midreset_pkts", 64'(pkts_sent), 64'(0));
    repeat (2) @(negedge clk);
    checkOutput("midreset_stays_idle", 64'(tvalid), 64'(0));

    for (int r = 0; r < 6; r++) begin
      rv.len       = $urandom_range(1, 8);
      rv.num       = $urandom_range(1, 5);
      rv.gapCycles = $urandom_range(0, 4);
      rv.seedVal   = $urandom;
      rv.readyPct  = $urandom_range(30, 100);
      rv.stopBeat  = ($urandom_range(1) == 1) ? int'($urandom_range(0, rv.len * rv.num - 1)) : -1;
      rv.midStart  = -1;
      rv.expPkts   = modelPkts(rv);
      applyStimulus(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
